// File: rtl/median_filter_stream.sv
// Streaming 1-D median filter: one frame of frame_len samples in, one median per full
// WINDOW-deep window out, with start/busy/done frame control.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; frame_len latched on start
// S_RUN   | accepting samples, emitting medians once the window is full
// S_DRAIN | all samples taken; waiting for the last median to be taken
// S_DONE  | one-cycle done pulse, back to S_IDLE
module median_filter_stream #(
    parameter int WIDTH  = 32,
    parameter int WINDOW = 3,
    parameter int LEN_W  = 16,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int MID = (WINDOW - 1) / 2;

    if ((WINDOW < 3) || (WINDOW > 15) || ((WINDOW % 2) == 0)) begin : g_bad_window
        $error("median_filter_stream: WINDOW must be odd and within 3..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_in_cnt;
    logic [WIDTH-1:0]   r_win [WINDOW];
    logic [WIDTH-1:0]   w_win_nxt [WINDOW];
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [WIDTH-1:0]   w_median;
    logic               w_in_ready;
    logic               w_in_hs;
    logic [LEN_W:0]     w_in_cnt_inc;
    logic               w_load;
    logic               w_last;

    function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) < $signed(b);
        else             return a < b;
    endfunction

    // The in_ready gate on a pending median means a load can never overwrite an unconsumed one.
    assign w_in_ready   = (r_state == S_RUN) && (r_in_cnt < r_len) && (!r_out_valid || out_ready);
    assign w_in_hs      = in_valid && w_in_ready;
    assign w_in_cnt_inc = {1'b0, r_in_cnt} + {{LEN_W{1'b0}}, 1'b1};
    assign w_load       = w_in_hs && (w_in_cnt_inc >= (LEN_W + 1)'(WINDOW));
    assign w_last       = w_in_hs && (w_in_cnt_inc == {1'b0, r_len});

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

    // Rank selection: ties are broken by position, so exactly one element has rank MID.
    always_comb begin
        logic [3:0] rank;
        w_median = '0;
        rank     = '0;
        w_win_nxt[0] = in_data;
        for (int k = 1; k < WINDOW; k++) begin
            w_win_nxt[k] = r_win[k-1];
        end
        for (int j = 0; j < WINDOW; j++) begin
            rank = '0;
            for (int k = 0; k < WINDOW; k++) begin
                if (lt(w_win_nxt[k], w_win_nxt[j])) rank = rank + 4'd1;
                if ((k < j) && (w_win_nxt[k] == w_win_nxt[j])) rank = rank + 4'd1;
            end
            if (rank == 4'(MID)) w_median = w_win_nxt[j];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = (frame_len == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_out_valid || out_ready) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_in_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int k = 0; k < WINDOW; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && start) begin
                r_len    <= frame_len;
                r_in_cnt <= '0;
            end else if (w_in_hs) begin
                r_in_cnt <= w_in_cnt_inc[LEN_W-1:0];
            end
            if (w_in_hs) begin
                for (int k = 0; k < WINDOW; k++) begin
                    r_win[k] <= w_win_nxt[k];
                end
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_median;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
